// File: rtl/calc_pkg.sv
// Shared calculator definitions: entry FSM states, status LED encodings and
// the operator codes the ALU decodes from op_code.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GOT_A = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] LED_IDLE  = 3'b001;
    localparam logic [2:0] LED_GOT_A = 3'b010;
    localparam logic [2:0] LED_DONE  = 3'b100;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    function automatic logic [2:0] led_of(input state_t s);
        logic [2:0] l;
        l = LED_IDLE;
        case (s)
            ST_IDLE:  l = LED_IDLE;
            ST_GOT_A: l = LED_GOT_A;
            ST_DONE:  l = LED_DONE;
            default:  l = LED_IDLE;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Key debouncer: two-flop synchroniser, saturating stability counter and a
// one-cycle press pulse on the rising edge of the debounced level.
module key_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;
    logic          level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            count   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1   <= key_raw;
            sync2   <= sync1;
            level_q <= level;
            // Any low sample restarts the stability window.
            if (!sync2)
                count <= '0;
            else if (count != DEB_MAX)
                count <= count + 1'b1;
        end
    end

    assign level = (count == DEB_MAX);
    assign press = level & ~level_q;

endmodule

// File: rtl/calc_operand_entry.sv
// Calculator operand/operator entry: captures A, then B plus operator, and
// offers the complete set to the ALU over a valid/ready handshake.
module calc_operand_entry
    import calc_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int OP_W       = 2,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_number,
    input  logic [OP_W-1:0]  op_sel,
    input  logic             k_enter,
    input  logic             k_clear,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [OP_W-1:0]  op_code,
    output logic [WIDTH-1:0] disp_data,
    output logic [2:0]       led
);

    state_t state;
    state_t state_next;
    logic   enter_p;
    logic   clear_p;
    logic   enter_level;
    logic   clear_level;
    logic   unused_levels;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_enter_deb (
        .clk     (clk),
        .rst     (rst),
        .key_raw (k_enter),
        .level   (enter_level),
        .press   (enter_p)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clear_deb (
        .clk     (clk),
        .rst     (rst),
        .key_raw (k_clear),
        .level   (clear_level),
        .press   (clear_p)
    );

    assign unused_levels = enter_level ^ clear_level;

    // Clear overrides everything, including an accepting handshake in DONE.
    always_comb begin
        state_next = state;
        if (clear_p) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (enter_p)   state_next = ST_GOT_A;
                ST_GOT_A: if (enter_p)   state_next = ST_DONE;
                ST_DONE:  if (out_ready) state_next = ST_IDLE;
                default:                 state_next = ST_IDLE;
            endcase
        end
    end

    // valid and led follow the next state so they stay registered yet in step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            operand_a <= '0;
            operand_b <= '0;
            op_code   <= '0;
            out_valid <= 1'b0;
            led       <= LED_IDLE;
        end else begin
            state     <= state_next;
            out_valid <= (state_next == ST_DONE);
            led       <= led_of(state_next);
            if (clear_p) begin
                operand_a <= '0;
                operand_b <= '0;
                op_code   <= '0;
            end else if (state == ST_IDLE && enter_p) begin
                operand_a <= in_number;
            end else if (state == ST_GOT_A && enter_p) begin
                operand_b <= in_number;
                op_code   <= op_sel;
            end
        end
    end

    assign disp_data = (state == ST_DONE) ? operand_b : in_number;

endmodule
